zverif_mmio: RTL and testbench
==============================

ZVERIF_MMIO -- requirements
Module: zverif_mmio

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8 (power of 2, 2..256), the console FIFO depth in bytes.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h1000_0000, the base of the 16-byte MMIO window.
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 resetn  in  1  reset, synchronous, active-low.
REQ-005 s_awaddr in 32, s_awvalid in 1, s_awready out 1: AXI-Lite write address channel from the CPU.
REQ-006 s_wdata in 32, s_wstrb in 4, s_wvalid in 1, s_wready out 1: AXI-Lite write data channel.
REQ-007 s_bresp out 2, s_bvalid out 1, s_bready in 1: AXI-Lite write response channel.
REQ-008 s_araddr in 32, s_arvalid in 1, s_arready out 1: AXI-Lite read address channel.
REQ-009 s_rdata out 32, s_rresp out 2, s_rvalid out 1, s_rready in 1: AXI-Lite read data channel.
REQ-010 con_data out 8, con_valid out 1, con_ready in 1: console byte stream to the host.
REQ-011 exit_valid out 1, exit_code out 16: simulation-exit request and code to the host.

Function
REQ-012 Register map (offsets from BASE_ADDR): 0x0 CONSOLE (W), 0x4 STATUS (R), 0x8 EXIT (W). Decode uses full 32-bit address equality; s_wstrb is ignored.
REQ-013 Write FSM states: IDLE, ACK, RESP.
REQ-014 IDLE -> ACK when s_awvalid & s_wvalid both high, except a CONSOLE write while the FIFO is full, which stays in IDLE until not full.
REQ-015 In ACK (exactly one cycle), s_awready = s_wready = 1; the write side effect occurs on the ACK clock edge; then go to RESP.
REQ-016 In RESP, s_bvalid = 1 with s_bresp stable; return to IDLE on the edge where s_bready = 1.
REQ-017 Minimum write latency: valid sampled at edge N -> ready high in cycle N+1 -> bvalid high from cycle N+2.
REQ-018 A CONSOLE write SHALL push s_wdata[7:0] into the FIFO; bresp = OKAY (2'b00).
REQ-019 An EXIT write with wdata[15:0] == 16'h3333 SHALL set exit_code = wdata[31:16]; wdata[15:0] == 16'h5555 SHALL set exit_code = 0; either case sets exit_valid = 1; other values have no effect; bresp = OKAY.
REQ-020 exit_valid and exit_code are sticky until reset; the first accepted exit wins and later EXIT writes are ignored (OKAY).
REQ-021 A write to any other address (STATUS included) SHALL have no side effect and respond SLVERR (2'b10).
REQ-022 Read FSM states: RIDLE, RACK, RDATA; it is independent of the write FSM.
REQ-023 Read transitions: RIDLE -> RACK on s_arvalid; RACK has s_arready = 1 for one cycle and captures s_rdata; RDATA holds s_rvalid = 1 until s_rready, then -> RIDLE.
REQ-024 STATUS read data: [0] = FIFO full, [1] = FIFO empty, [2] = exit_valid, [15:8] = FIFO count, all other bits 0; rresp = OKAY.
REQ-025 A read of any other address SHALL return 0 with rresp = SLVERR.
REQ-026 The FIFO is show-ahead: con_valid = !empty and con_data = head byte; a pop occurs on con_valid & con_ready.
REQ-027 A simultaneous push and pop SHALL leave the count unchanged and preserve byte order.
REQ-028 Pointers wrap modulo FIFO_DEPTH; the count ranges 0..FIFO_DEPTH.
REQ-029 No byte is ever dropped or duplicated; a full FIFO only back-pressures the CPU through REQ-014.
REQ-030 Outputs change only on clk edges; no combinational path from any input to any output.

Reset
REQ-031 While resetn = 0 at an edge: both FSMs go to IDLE/RIDLE and the FIFO is emptied.
REQ-032 While resetn = 0 at an edge: all of s_awready, s_wready, s_bvalid, s_arready, s_rvalid, con_valid and exit_valid = 0.
REQ-033 While resetn = 0 at an edge: s_bresp, s_rresp, s_rdata, exit_code and con_data = 0.
REQ-034 A reset mid-transaction SHALL abandon any pending response; no side effect of the interrupted transfer is retained unless its ACK edge preceded reset.

Verification
REQ-035 Write 0x41 to CONSOLE with con_ready = 1 -> awready/wready pulse 1 cycle, bvalid next cycle with OKAY, con_data = 0x41 with con_valid for 1 cycle.
REQ-036 con_ready = 0; write FIFO_DEPTH+1 bytes -> first 8 complete, the 9th stalls with awready low. Raise con_ready -> bytes drain in order, the 9th is accepted, 9 bytes total are seen.
REQ-037 EXIT write 0x0007_3333 -> exit_valid = 1, exit_code = 7; a subsequent 0x0000_5555 -> exit_code stays 7.
REQ-038 Write to BASE+0xC and read BASE+0x20 -> bresp = 2'b10; rdata = 0 with rresp = 2'b10.
REQ-039 Push 3 bytes with con_ready = 0, read STATUS -> rdata = 0x0000_0300. Hold s_bready = 0 for 5 cycles -> bvalid stays high and bresp stays stable.
REQ-040 Assert resetn = 0 during RESP with 2 bytes queued -> next cycle bvalid = 0, con_valid = 0, exit_valid = 0, and STATUS reads 0x0000_0002.

Source files
------------

// File: rtl/zverif_mmio.sv
// rtl/zverif_mmio.sv - AXI-Lite MMIO window exposing a console byte FIFO, a status word and a sim-exit register.
module zverif_mmio #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] s_awaddr,
  input  logic        s_awvalid,
  output logic        s_awready,
  input  logic [31:0] s_wdata,
  input  logic [3:0]  s_wstrb,
  input  logic        s_wvalid,
  output logic        s_wready,
  output logic [1:0]  s_bresp,
  output logic        s_bvalid,
  input  logic        s_bready,
  input  logic [31:0] s_araddr,
  input  logic        s_arvalid,
  output logic        s_arready,
  output logic [31:0] s_rdata,
  output logic [1:0]  s_rresp,
  output logic        s_rvalid,
  input  logic        s_rready,
  output logic [7:0]  con_data,
  output logic        con_valid,
  input  logic        con_ready,
  output logic        exit_valid,
  output logic [15:0] exit_code
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [31:0] CON_ADDR  = BASE_ADDR;
  localparam logic [31:0] STAT_ADDR = BASE_ADDR + 32'h4;
  localparam logic [31:0] EXIT_ADDR = BASE_ADDR + 32'h8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_ACK, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ACK, R_DATA} rstate_t;

  wstate_t wstate;
  rstate_t rstate;

  logic [31:0] waddr_q;
  logic [31:0] wdata_q;
  logic [31:0] raddr_q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic [8:0]    count9;
  logic [31:0]   status_word;

  // s_wstrb has no effect: every register takes the whole word.
  logic unused_wstrb;
  assign unused_wstrb = ^s_wstrb;

  assign full   = (count == CW'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign push   = (wstate == W_ACK) && (waddr_q == CON_ADDR);
  assign pop    = !empty && con_ready;
  assign count9 = 9'(count);

  assign status_word = {16'h0000, count9[7:0], 5'b00000, exit_valid, empty, full};

  assign con_valid = !empty;
  assign con_data  = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (resetn && push) begin
      mem[wr_ptr] <= wdata_q[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A console write is only accepted with room in the FIFO, so the push on the ACK edge never overflows.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wstate     <= W_IDLE;
      s_awready  <= 1'b0;
      s_wready   <= 1'b0;
      s_bvalid   <= 1'b0;
      s_bresp    <= RESP_OKAY;
      waddr_q    <= '0;
      wdata_q    <= '0;
      exit_valid <= 1'b0;
      exit_code  <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (s_awvalid && s_wvalid && !((s_awaddr == CON_ADDR) && full)) begin
            wstate    <= W_ACK;
            s_awready <= 1'b1;
            s_wready  <= 1'b1;
            waddr_q   <= s_awaddr;
            wdata_q   <= s_wdata;
          end
        end
        W_ACK: begin
          wstate    <= W_RESP;
          s_awready <= 1'b0;
          s_wready  <= 1'b0;
          s_bvalid  <= 1'b1;
          if (waddr_q == CON_ADDR) begin
            s_bresp <= RESP_OKAY;
          end else if (waddr_q == EXIT_ADDR) begin
            s_bresp <= RESP_OKAY;
            // First accepted exit is sticky; later exits are acknowledged but ignored.
            if (!exit_valid) begin
              if (wdata_q[15:0] == 16'h3333) begin
                exit_valid <= 1'b1;
                exit_code  <= wdata_q[31:16];
              end else if (wdata_q[15:0] == 16'h5555) begin
                exit_valid <= 1'b1;
                exit_code  <= 16'h0000;
              end
            end
          end else begin
            s_bresp <= RESP_SLVERR;
          end
        end
        W_RESP: begin
          if (s_bready) begin
            wstate   <= W_IDLE;
            s_bvalid <= 1'b0;
          end
        end
        default: begin
          wstate <= W_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rstate    <= R_IDLE;
      s_arready <= 1'b0;
      s_rvalid  <= 1'b0;
      s_rdata   <= '0;
      s_rresp   <= RESP_OKAY;
      raddr_q   <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (s_arvalid) begin
            rstate    <= R_ACK;
            s_arready <= 1'b1;
            raddr_q   <= s_araddr;
          end
        end
        R_ACK: begin
          rstate    <= R_DATA;
          s_arready <= 1'b0;
          s_rvalid  <= 1'b1;
          if (raddr_q == STAT_ADDR) begin
            s_rdata <= status_word;
            s_rresp <= RESP_OKAY;
          end else begin
            s_rdata <= 32'h0000_0000;
            s_rresp <= RESP_SLVERR;
          end
        end
        R_DATA: begin
          if (s_rready) begin
            rstate   <= R_IDLE;
            s_rvalid <= 1'b0;
          end
        end
        default: begin
          rstate <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_zverif_mmio.sv
// tb/tb_zverif_mmio.sv - self-checking bench for zverif_mmio with a console byte scoreboard.
module tb_zverif_mmio;

  localparam int          DEPTH = 8;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] CON   = BASE;
  localparam logic [31:0] STAT  = BASE + 32'h4;
  localparam logic [31:0] EXITA = BASE + 32'h8;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b1;
  logic [31:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b1;
  logic [7:0]  con_data;
  logic        con_valid;
  logic        con_ready = 1'b0;
  logic        exit_valid;
  logic [15:0] exit_code;

  int checks = 0;
  int errors = 0;
  int popped = 0;
  int aw_wait;
  int b_wait;
  logic aw_after;
  logic [7:0] exp_q[$];

  zverif_mmio #(.FIFO_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .resetn(resetn),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .con_data(con_data), .con_valid(con_valid), .con_ready(con_ready),
    .exit_valid(exit_valid), .exit_code(exit_code)
  );

  always #5 clk = ~clk;

  // Console scoreboard: a byte leaves on the next rising edge when valid and ready are both high here.
  always @(negedge clk) begin
    if (resetn && con_valid && con_ready) begin
      checks++;
      popped++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL con_unexpected got 0x%02h required no byte", con_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (con_data !== e) begin
          errors++;
          $display("FAIL con_data got 0x%02h required 0x%02h", con_data, e);
        end
      end
    end
  end

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    s_awaddr = a; s_awvalid = 1'b1; s_wdata = d; s_wstrb = 4'hf; s_wvalid = 1'b1; s_bready = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_awready && n < 300);
    aw_wait = n;
    resp = 2'bxx;
    if (!s_awready) begin
      checks++; errors++;
      $display("FAIL write_timeout addr=0x%08h got awready=0 required 1", a);
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
    aw_after = s_awready;
    n = 0;
    while (!s_bvalid && n < 20) begin @(negedge clk); n++; end
    b_wait = n;
    if (!s_bvalid) begin
      checks++; errors++;
      $display("FAIL bvalid_timeout addr=0x%08h got bvalid=0 required 1", a);
      return;
    end
    resp = s_bresp;
    @(posedge clk); #1;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    @(posedge clk); #1;
    s_araddr = a; s_arvalid = 1'b1; s_rready = 1'b1;
    d = 'x; resp = 2'bxx;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_arready && n < 50);
    if (!s_arready) begin
      checks++; errors++;
      $display("FAIL read_timeout addr=0x%08h got arready=0 required 1", a);
      s_arvalid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    s_arvalid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_rvalid && n < 20);
    if (!s_rvalid) begin
      checks++; errors++;
      $display("FAIL rvalid_timeout addr=0x%08h got rvalid=0 required 1", a);
      return;
    end
    d = s_rdata; resp = s_rresp;
    @(posedge clk); #1;
  endtask

  task automatic con_write(input logic [7:0] b);
    logic [1:0] r;
    exp_q.push_back(b);
    axi_write(CON, {24'hABCDEF, b}, r);
    checks++;
    if (r !== 2'b00) begin
      errors++;
      $display("FAIL con_bresp byte=0x%02h got %b required 00", b, r);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((con_valid || exp_q.size() != 0) && n < 60) begin @(negedge clk); n++; end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid, con_valid, exit_valid,
         s_bresp, s_rresp, s_rdata, exit_code, con_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got aw=%b w=%b b=%b ar=%b r=%b cv=%b ev=%b bresp=%b rresp=%b rdata=0x%h code=0x%h cd=0x%h required all 0",
               s_awready, s_wready, s_bvalid, s_arready, s_rvalid, con_valid, exit_valid,
               s_bresp, s_rresp, s_rdata, exit_code, con_data);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
  endtask

  task automatic test_console();
    int p0;
    p0 = popped;
    con_ready = 1'b1;
    con_write(8'h41);
    checks++;
    if (aw_wait !== 2) begin
      errors++; $display("FAIL con_aw_latency got %0d required 2", aw_wait);
    end
    checks++;
    if (aw_after !== 1'b0) begin
      errors++; $display("FAIL con_awready_pulse got %b required 0", aw_after);
    end
    checks++;
    if (b_wait !== 0) begin
      errors++; $display("FAIL con_b_latency got %0d required 0", b_wait);
    end
    @(negedge clk);
    checks++;
    if (con_valid !== 1'b0 || (popped - p0) !== 1) begin
      errors++; $display("FAIL con_single_pop got valid=%b pops=%0d required valid=0 pops=1", con_valid, popped - p0);
    end
  endtask

  task automatic test_backpressure();
    int p0;
    p0 = popped;
    con_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) con_write(8'h10 + 8'(i));
    fork
      begin
        con_write(8'h10 + 8'(DEPTH));
      end
      begin
        logic seen;
        logic [31:0] d;
        logic [1:0] rr;
        seen = 1'b0;
        repeat (6) begin @(negedge clk); if (s_awready) seen = 1'b1; end
        checks++;
        if (seen !== 1'b0) begin
          errors++; $display("FAIL full_stall got awready=1 required 0");
        end
        axi_read(STAT, d, rr);
        checks++;
        if (d !== 32'h0000_0801 || rr !== 2'b00) begin
          errors++; $display("FAIL full_status got 0x%08h/%b required 0x00000801/00", d, rr);
        end
        con_ready = 1'b1;
      end
    join
    wait_drain();
    checks++;
    if (exp_q.size() !== 0 || (popped - p0) !== DEPTH + 1) begin
      errors++; $display("FAIL drain_count got pops=%0d left=%0d required pops=%0d left=0", popped - p0, exp_q.size(), DEPTH + 1);
    end
  endtask

  task automatic test_slverr();
    logic [1:0] r;
    logic [31:0] d;
    axi_write(BASE + 32'hC, 32'h0000_0055, r);
    checks++;
    if (r !== 2'b10) begin
      errors++; $display("FAIL slverr_write got %b required 10", r);
    end
    axi_write(STAT, 32'h0000_0066, r);
    checks++;
    if (r !== 2'b10 || con_valid !== 1'b0) begin
      errors++; $display("FAIL slverr_status_write got %b cv=%b required 10 cv=0", r, con_valid);
    end
    axi_read(BASE + 32'h20, d, r);
    checks++;
    if (d !== 32'h0 || r !== 2'b10) begin
      errors++; $display("FAIL slverr_read got 0x%08h/%b required 0x00000000/10", d, r);
    end
    axi_read(STAT, d, r);
    checks++;
    if (d !== 32'h0000_0002 || r !== 2'b00) begin
      errors++; $display("FAIL idle_status got 0x%08h/%b required 0x00000002/00", d, r);
    end
  endtask

  task automatic test_status_hold();
    logic [31:0] d;
    logic [1:0] r;
    logic bad;
    int n;
    con_ready = 1'b0;
    for (int i = 0; i < 3; i++) con_write(8'h61 + 8'(i));
    axi_read(STAT, d, r);
    checks++;
    if (d !== 32'h0000_0300 || r !== 2'b00) begin
      errors++; $display("FAIL status_three got 0x%08h/%b required 0x00000300/00", d, r);
    end
    exp_q.push_back(8'h64);
    @(posedge clk); #1;
    s_awaddr = CON; s_wdata = 32'h0000_0064; s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_awready && n < 50);
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) bad = 1'b1;
    end
    checks++;
    if (bad !== 1'b0) begin
      errors++; $display("FAIL bresp_hold got bvalid=%b bresp=%b required 1/00 held", s_bvalid, s_bresp);
    end
    @(posedge clk); #1;
    s_bready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_bvalid !== 1'b0) begin
      errors++; $display("FAIL bvalid_release got %b required 0", s_bvalid);
    end
    con_ready = 1'b1;
    wait_drain();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++; $display("FAIL hold_drain got left=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_exit();
    logic [1:0] r;
    logic [31:0] d;
    axi_write(EXITA, 32'h0007_1234, r);
    checks++;
    if (r !== 2'b00 || exit_valid !== 1'b0) begin
      errors++; $display("FAIL exit_ignore got bresp=%b ev=%b required 00/0", r, exit_valid);
    end
    axi_write(EXITA, 32'h0007_3333, r);
    checks++;
    if (r !== 2'b00 || exit_valid !== 1'b1 || exit_code !== 16'd7) begin
      errors++; $display("FAIL exit_code got bresp=%b ev=%b code=%0d required 00/1/7", r, exit_valid, exit_code);
    end
    axi_write(EXITA, 32'h0000_5555, r);
    checks++;
    if (r !== 2'b00 || exit_valid !== 1'b1 || exit_code !== 16'd7) begin
      errors++; $display("FAIL exit_sticky got bresp=%b ev=%b code=%0d required 00/1/7", r, exit_valid, exit_code);
    end
    axi_read(STAT, d, r);
    checks++;
    if (d !== 32'h0000_0006) begin
      errors++; $display("FAIL exit_status got 0x%08h required 0x00000006", d);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [1:0] r;
    int n;
    con_ready = 1'b0;
    con_write(8'h71);
    con_write(8'h72);
    @(posedge clk); #1;
    s_awaddr = STAT; s_wdata = 32'h0; s_awvalid = 1'b1; s_wvalid = 1'b1; s_bready = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!s_awready && n < 50);
    @(posedge clk); #1;
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_bvalid !== 1'b1 || con_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset got bvalid=%b cv=%b required 1/1", s_bvalid, con_valid);
    end
    @(posedge clk); #1;
    resetn = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (s_bvalid !== 1'b0 || con_valid !== 1'b0 || exit_valid !== 1'b0 || exit_code !== 16'h0 ||
        con_data !== 8'h00 || s_rdata !== 32'h0) begin
      errors++; $display("FAIL mid_reset got bvalid=%b cv=%b ev=%b code=0x%h cd=0x%h rdata=0x%h required all 0",
                         s_bvalid, con_valid, exit_valid, exit_code, con_data, s_rdata);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    s_bready = 1'b1;
    axi_read(STAT, d, r);
    checks++;
    if (d !== 32'h0000_0002 || r !== 2'b00) begin
      errors++; $display("FAIL post_reset_status got 0x%08h/%b required 0x00000002/00", d, r);
    end
  endtask

  initial begin
    test_reset();
    test_console();
    test_backpressure();
    test_slverr();
    test_status_hold();
    test_exit();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got still running required finished");
    $fatal(1);
  end

endmodule
